seq_arithmetic_left_shift: RTL and testbench

//  Multi-cycle arithmetic left shifter for the 16-bit ALU datapath.

---
 rtl/seq_arithmetic_left_shift_pkg.sv | 31 +++
 rtl/seq_arithmetic_left_shift_if.sv | 30 +++
 rtl/seq_arithmetic_left_shift.sv | 116 +++++++++++
 tb/tb_seq_arithmetic_left_shift.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_arithmetic_left_shift_pkg.sv
// Shared definitions for the sequential arithmetic shifters of the 16-bit ALU.
// Contents: operand and counter widths, the shift-amount clamp constant,
// the one-hot FSM state encoding, and the shift-count clamp helper.
package seq_arithmetic_left_shift_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    // A shift by the full width or more always gives the same result as a
    // shift by exactly WIDTH.
    localparam logic [CNT_W-1:0] MAX_SHIFT = 5'd16;

    // One-hot encoding lets busy/done come straight from one state flop each.
    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_SHIFT = 3'b010,
        S_DONE  = 3'b100
    } state_t;

    // Reduce a full-width shift amount to a counter value in 0..MAX_SHIFT.
    function automatic logic [CNT_W-1:0] clamp_shift(input logic [WIDTH-1:0] amount);
        logic [CNT_W-1:0] result;
        if ((|amount[WIDTH-1:CNT_W]) || (amount[CNT_W-1:0] > MAX_SHIFT)) begin
            result = MAX_SHIFT;
        end else begin
            result = amount[CNT_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_arithmetic_left_shift_if.sv
// Request/result bundle between the ALU controller and the sequential
// arithmetic left shifter.
//   start     controller -> shifter  request, sampled in IDLE or DONE
//   A, B      controller -> shifter  operand and shift amount
//   Y         shifter -> controller  registered result
//   overflow  shifter -> controller  registered signed-overflow flag
//   busy      shifter -> controller  shift in progress
//   done      shifter -> controller  one-cycle completion pulse
interface seq_arithmetic_left_shift_if;
    import seq_arithmetic_left_shift_pkg::*;

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Y;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B,
        input  Y, overflow, busy, done
    );

    modport slave (
        input  start, A, B,
        output Y, overflow, busy, done
    );

endinterface

// File: rtl/seq_arithmetic_left_shift.sv
// Multi-cycle arithmetic left shifter: shifts A left by B (clamped to 16)
// one bit per clock, zero-filling from the LSB, and flags signed overflow
// whenever the sign bit changes at any step.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of seq_arithmetic_left_shift_if (start/A/B in,
//        Y/overflow/busy/done out)
module seq_arithmetic_left_shift
    import seq_arithmetic_left_shift_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    seq_arithmetic_left_shift_if.slave  bus
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;
    logic [WIDTH-1:0] y_reg;
    logic             ovf_reg;
    logic             busy_dec;
    logic             done_dec;

    logic             accept;
    logic [CNT_W-1:0] load_cnt;
    logic [WIDTH-1:0] shifted;
    logic             ovf_next;

    // Operand acceptance and one-step shift values shared by FSM and datapath.
    always_comb begin
        accept   = bus.start && ((state == S_IDLE) || (state == S_DONE));
        load_cnt = clamp_shift(bus.B);
        shifted  = {work[WIDTH-2:0], 1'b0};
        // A sign change at this step shows up as the top two bits differing.
        ovf_next = ovf_acc | (work[WIDTH-1] ^ work[WIDTH-2]);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (load_cnt == 5'd0) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_SHIFT;
                    end
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (cnt == 5'd1) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_SHIFT;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        busy_dec = (state == S_SHIFT);
        done_dec = (state == S_DONE);
    end

    // Work register, counter, sticky overflow and the result registers.
    // Y/overflow are written only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work    <= 16'h0000;
            cnt     <= 5'd0;
            ovf_acc <= 1'b0;
            y_reg   <= 16'h0000;
            ovf_reg <= 1'b0;
        end else if (accept) begin
            work    <= bus.A;
            cnt     <= load_cnt;
            ovf_acc <= 1'b0;
            // A zero-length shift completes immediately with A unchanged.
            if (load_cnt == 5'd0) begin
                y_reg   <= bus.A;
                ovf_reg <= 1'b0;
            end
        end else if (state == S_SHIFT) begin
            work    <= shifted;
            cnt     <= cnt - 5'd1;
            ovf_acc <= ovf_next;
            if (cnt == 5'd1) begin
                y_reg   <= shifted;
                ovf_reg <= ovf_next;
            end
        end
    end

    assign bus.Y        = y_reg;
    assign bus.overflow = ovf_reg;
    assign bus.busy     = busy_dec;
    assign bus.done     = done_dec;

endmodule

// File: tb/tb_seq_arithmetic_left_shift.sv
// Self-checking bench for seq_arithmetic_left_shift: directed vector table,
// B sweep and random operands against an arithmetic reference model, plus
// hand-written handshake and asynchronous-reset sequences.
module tb_seq_arithmetic_left_shift;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    seq_arithmetic_left_shift_if bus_if();

    seq_arithmetic_left_shift dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_y;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: Y = A * 2^N truncated to 16 bits; overflow if the sign of
    // any intermediate A * 2^i (i = 1..N) differs from the sign of A.
    function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] y, output logic ovf, output int n);
        logic [31:0] t;
        n   = (b > 16'd16) ? 16 : int'(b);
        t   = {16'h0000, a} << n;
        y   = t[15:0];
        ovf = 1'b0;
        for (int i = 1; i <= n; i++) begin
            t = {16'h0000, a} << i;
            if (t[15] != a[15]) ovf = 1'b1;
        end
    endfunction

    // Issue one op, scramble the operands after acceptance, and wait for done.
    // lat counts cycles from the accepting edge to the cycle with done high.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] y, output logic ovf, output int lat);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.A     = a;
        bus_if.B     = b;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.A     = 16'($urandom);
        bus_if.B     = 16'($urandom);
        lat = 1;
        while (!bus_if.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        y   = bus_if.Y;
        ovf = bus_if.overflow;
    endtask

    // Run one op and compare result, flag, latency, done width and Y hold.
    task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_y, input logic exp_ovf, input int exp_lat);
        logic [15:0] y;
        logic        ovf;
        int          lat;
        run_op(a, b, y, ovf, lat);
        check({name, "_y"}, 32'(y), 32'(exp_y));
        check({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(bus_if.done), 32'd0);
        check({name, "_y_hold"}, 32'(bus_if.Y), 32'(exp_y));
    endtask

    task automatic model_op(input string name, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] y;
        logic        ovf;
        int          n;
        ref_model(a, b, y, ovf, n);
        check_op(name, a, b, y, ovf, n + 1);
    endtask

    vec_t vecs[7];

    initial begin
        int          lat;
        logic [15:0] prev_y;
        checks   = 0;
        failures = 0;
        bus_if.start = 1'b0;
        bus_if.A     = 16'h0000;
        bus_if.B     = 16'h0000;
        rst = 1'b1;

        vecs[0] = '{16'hC000, 16'd1,     16'h8000, 1'b0, 2};
        vecs[1] = '{16'hC000, 16'd2,     16'h0000, 1'b1, 3};
        vecs[2] = '{16'hFFFF, 16'd15,    16'h8000, 1'b0, 16};
        vecs[3] = '{16'h0001, 16'd15,    16'h8000, 1'b1, 16};
        vecs[4] = '{16'h1234, 16'h0100,  16'h0000, 1'b1, 17};
        vecs[5] = '{16'h0000, 16'd20,    16'h0000, 1'b0, 17};
        vecs[6] = '{16'hA5A5, 16'd0,     16'hA5A5, 1'b0, 1};

        repeat (2) @(negedge clk);
        check("reset_y", 32'(bus_if.Y), 32'd0);
        check("reset_ovf", 32'(bus_if.overflow), 32'd0);
        check("reset_busy", 32'(bus_if.busy), 32'd0);
        check("reset_done", 32'(bus_if.done), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                     vecs[i].exp_y, vecs[i].exp_ovf, vecs[i].exp_lat);
        end

        for (int b = 0; b < 16; b++) begin
            model_op($sformatf("sweep_b%0d", b), 16'hC000, 16'(b));
        end

        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
            model_op($sformatf("rand%0d", i), ra, rb);
        end

        // start pulsed mid-SHIFT with new operands must be ignored.
        prev_y = bus_if.Y;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.A = 16'h0003; bus_if.B = 16'd6;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.A = 16'hFFFF; bus_if.B = 16'd1;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("ign_busy", 32'(bus_if.busy), 32'd1);
        check("ign_y_stable", 32'(bus_if.Y), 32'(prev_y));
        lat = 3;
        while (!bus_if.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("ign_lat", 32'(lat), 32'd7);
        check("ign_y", 32'(bus_if.Y), 32'h00C0);
        check("ign_ovf", 32'(bus_if.overflow), 32'd0);

        // start held in DONE accepts the next op back-to-back.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.A = 16'h0101; bus_if.B = 16'd3;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        lat = 1;
        while (!bus_if.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_first_lat", 32'(lat), 32'd4);
        check("b2b_first_y", 32'(bus_if.Y), 32'h0808);
        bus_if.start = 1'b1; bus_if.A = 16'h4001; bus_if.B = 16'd2;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        check("b2b_done_low", 32'(bus_if.done), 32'd0);
        check("b2b_busy", 32'(bus_if.busy), 32'd1);
        check("b2b_y_stable", 32'(bus_if.Y), 32'h0808);
        lat = 1;
        while (!bus_if.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_lat", 32'(lat), 32'd3);
        check("b2b_second_y", 32'(bus_if.Y), 32'h0004);
        check("b2b_second_ovf", 32'(bus_if.overflow), 32'd1);

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.A = 16'h00FF; bus_if.B = 16'd8;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_y", 32'(bus_if.Y), 32'd0);
        check("arst_ovf", 32'(bus_if.overflow), 32'd0);
        check("arst_busy", 32'(bus_if.busy), 32'd0);
        check("arst_done", 32'(bus_if.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check_op("post_rst", 16'h0003, 16'd1, 16'h0006, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
